lsu_stage: RTL and testbench
============================

LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter: WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 exu_valid  input  1  EXU has a valid packet on exu_data.
REQ-005 exu_data  input  109  EXU packet (fields per REQ-020).
REQ-006 lsu_ready  output  1  stage can accept a packet this cycle.
REQ-007 mem_req_valid  output  1  memory request pending.
REQ-008 mem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 mem_req_wen  output  1  1 = store, 0 = load.
REQ-010 mem_req_addr  output  32  word-aligned address.
REQ-011 mem_req_wdata  output  32  lane-shifted store data.
REQ-012 mem_req_wstrb  output  4  byte-lane strobes; 0000 for loads.
REQ-013 mem_resp_valid  input  1  response (load data or store ack) this cycle.
REQ-014 mem_resp_rdata  input  32  aligned load word.
REQ-015 lsu_valid  output  1  lsu_data valid toward WBU.
REQ-016 lsu_data  output  38  {rd_wen, rd[4:0], wb_data[31:0]}.
REQ-017 wbu_ready  input  1  WBU accepts lsu_data this cycle.

Function
REQ-020 exu_data fields SHALL be: [108:77] alu_result, [76] mem_ren, [75] mem_wen, [74:72] funct3, [71:40] store_data, [39:35] rd, [34] rd_wen, [33:32] wb_sel, [31:0] csr_data.
REQ-021 States SHALL be IDLE, REQ, WAIT, OUT; lsu_ready = (state==IDLE), combinational.
REQ-022 Accept on exu_valid & lsu_ready: the whole packet SHALL be registered. Next state is REQ if mem_ren|mem_wen, else OUT.
REQ-023 mem_ren and mem_wen both set SHALL be treated as a load.
REQ-024 In REQ, mem_req_valid=1 and all mem_req_* SHALL be held stable until mem_req_ready; the request handshake moves the state to WAIT.
REQ-025 mem_req_addr SHALL be {alu_result[31:2],2'b00}; off = alu_result[1:0].
REQ-026 Strobes SHALL be: byte (funct3[1:0]=00) 0001<<off; half (01) 0011<<{off[1],1'b0}; word (10/11) 1111.
REQ-027 mem_req_wdata SHALL be store_data << (8*off) for byte, << (16*off[1]) for half, unshifted for word.
REQ-028 Misaligned accesses SHALL NOT trap; the lanes of REQ-026 apply.
REQ-029 In WAIT, mem_resp_valid SHALL move the state to OUT; mem_resp_valid in any other state SHALL be ignored.
REQ-030 Load data: field = rdata >> (8*off) for byte, >> (16*off[1]) for half. The field is sign-extended when funct3[2]=0 and zero-extended when funct3[2]=1.
REQ-031 wb_data select: 00 alu_result; 01 load data; 10 csr_data; 11 alu_result.
REQ-032 In OUT, lsu_valid=1 and lsu_data SHALL be held stable until wbu_ready; the handshake moves the state to IDLE.
REQ-033 Latency from the accept edge to the lsu_valid rise: 1 cycle for a non-memory packet; 3 cycles for a memory packet with zero-wait memory.
REQ-034 Throughput SHALL be at most one packet in flight; no new accept occurs before the OUT handshake.
REQ-035 A store SHALL still wait for mem_resp_valid before OUT.

Reset
REQ-040 rst=0 SHALL force IDLE immediately. lsu_valid, mem_req_valid, mem_req_wen, mem_req_wstrb, mem_req_addr, mem_req_wdata and lsu_data SHALL all be 0.
REQ-041 Reset during REQ/WAIT SHALL abandon the transaction; a response arriving after reset SHALL be ignored.

Verification
REQ-050 ALU pass-through: alu_result=0x00001234, wb_sel=00, rd=5, rd_wen=1, no mem -> lsu_valid 1 cycle after accept, lsu_data={1,5,0x00001234}, no mem_req_valid.
REQ-051 LB: alu_result=0x80000003, funct3=000, rdata=0x80FFFFFF -> mem_req_addr=0x80000000, wstrb=0000, wb_data=0xFFFFFF80.
REQ-052 LHU: alu_result=0x80000002, funct3=101, rdata=0xBEEF1234 -> wb_data=0x0000BEEF.
REQ-053 SB: alu_result=0x80000001, store_data=0x000000AB -> wen=1, wdata=0x0000AB00, wstrb=0010. rd_wen=0 propagates to lsu_data.
REQ-054 Backpressure: mem_req_ready low 3 cycles, then wbu_ready low 2 cycles -> request and lsu_data stable throughout; lsu_ready=0 until the OUT handshake.
REQ-055 Reset mid-WAIT, then mem_resp_valid pulse -> all outputs 0, state IDLE, lsu_ready=1, no lsu_valid generated.

Source files
------------

// File: rtl/lsu_stage.sv
// Load/store stage: registers one EXU packet, issues a single memory request,
// aligns load data and hands {rd_wen, rd, wb_data} to the writeback unit.
module lsu_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid,
  input  logic [108:0]     exu_data,
  output logic             lsu_ready,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_wen,
  output logic [WIDTH-1:0] mem_req_addr,
  output logic [WIDTH-1:0] mem_req_wdata,
  output logic [3:0]       mem_req_wstrb,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_rdata,
  output logic             lsu_valid,
  output logic [37:0]      lsu_data,
  input  logic             wbu_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;

  state_e       state_q, state_d;
  logic [108:0] pkt_q, pkt_d;
  logic [31:0]  rdata_q, rdata_d;

  logic [31:0] alu_result, store_data, csr_data, wb_data;
  logic        mem_ren, mem_wen, rd_wen, is_store;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  wb_sel, off;

  assign alu_result = pkt_q[108:77];
  assign mem_ren    = pkt_q[76];
  assign mem_wen    = pkt_q[75];
  assign funct3     = pkt_q[74:72];
  assign store_data = pkt_q[71:40];
  assign rd         = pkt_q[39:35];
  assign rd_wen     = pkt_q[34];
  assign wb_sel     = pkt_q[33:32];
  assign csr_data   = pkt_q[31:0];
  assign off        = alu_result[1:0];
  // A packet with both enables set behaves as a load.
  assign is_store   = mem_wen & ~mem_ren;

  function automatic logic [3:0] strb_f(input logic [1:0] sz, input logic [1:0] o);
    case (sz)
      2'b00:   strb_f = 4'b0001 << o;
      2'b01:   strb_f = 4'b0011 << {o[1], 1'b0};
      default: strb_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [1:0] o,
                                          input logic [31:0] sd);
    case (sz)
      2'b00:   wdata_f = sd << {o, 3'b000};
      2'b01:   wdata_f = sd << {o[1], 4'b0000};
      default: wdata_f = sd;
    endcase
  endfunction

  function automatic logic [31:0] load_f(input logic [2:0] f3, input logic [1:0] o,
                                         input logic [31:0] rdat);
    logic        [31:0] sh;
    logic signed [7:0]  b8;
    logic signed [15:0] h16;
    sh  = 32'd0;
    b8  = 8'sd0;
    h16 = 16'sd0;
    case (f3[1:0])
      2'b00: begin
        sh = rdat >> {o, 3'b000};
        b8 = sh[7:0];
        load_f = f3[2] ? {24'd0, sh[7:0]} : {{24{b8[7]}}, b8};
      end
      2'b01: begin
        sh  = rdat >> {o[1], 4'b0000};
        h16 = sh[15:0];
        load_f = f3[2] ? {16'd0, sh[15:0]} : {{16{h16[15]}}, h16};
      end
      default: load_f = rdat;
    endcase
  endfunction

  always_comb begin
    case (wb_sel)
      2'b01:   wb_data = load_f(funct3, off, rdata_q);
      2'b10:   wb_data = csr_data;
      default: wb_data = alu_result;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    rdata_d   = rdata_q;
    lsu_ready = (state_q == IDLE);
    case (state_q)
      IDLE: if (exu_valid) begin
        pkt_d   = exu_data;
        state_d = (exu_data[76] | exu_data[75]) ? REQ : OUT;
      end
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_resp_valid) begin
        rdata_d = mem_resp_rdata;
        state_d = OUT;
      end
      OUT:  if (wbu_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by state so reset alone clears them; packet regs need no reset.
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_wen   = mem_req_valid & is_store;
  assign mem_req_addr  = mem_req_valid ? {alu_result[31:2], 2'b00} : 32'd0;
  assign mem_req_wstrb = mem_req_wen ? strb_f(funct3[1:0], off) : 4'd0;
  assign mem_req_wdata = mem_req_wen ? wdata_f(funct3[1:0], off, store_data) : 32'd0;
  assign lsu_valid     = (state_q == OUT);
  assign lsu_data      = lsu_valid ? {rd_wen, rd, wb_data} : 38'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    pkt_q   <= pkt_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage with hand-computed expectations.
module tb_lsu_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         exu_valid;
  logic [108:0] exu_data;
  logic         lsu_ready;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_wen;
  logic [31:0]  mem_req_addr;
  logic [31:0]  mem_req_wdata;
  logic [3:0]   mem_req_wstrb;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_rdata;
  logic         lsu_valid;
  logic [37:0]  lsu_data;
  logic         wbu_ready;

  int checks   = 0;
  int failures = 0;

  lsu_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_data(exu_data), .lsu_ready(lsu_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .lsu_valid(lsu_valid), .lsu_data(lsu_data), .wbu_ready(wbu_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [108:0] mk(input logic [31:0] alu, input logic ren, input logic wen,
                                      input logic [2:0] f3, input logic [31:0] sd,
                                      input logic [4:0] rd, input logic rdw,
                                      input logic [1:0] wbs, input logic [31:0] csr);
    return {alu, ren, wen, f3, sd, rd, rdw, wbs, csr};
  endfunction

  // Zero-wait memory transaction: accept, REQ, WAIT with response, OUT handshake.
  task automatic run_mem(input string tag, input logic [108:0] pkt, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic e_wen,
                         input logic [31:0] e_wdata, input logic [3:0] e_strb,
                         input logic [37:0] e_out);
    exu_valid = 1'b1;
    exu_data  = pkt;
    #1;
    chk({tag, "_ready"}, lsu_ready, 1'b1);
    tick();
    exu_valid = 1'b0;
    chk({tag, "_reqv"},  mem_req_valid, 1'b1);
    chk({tag, "_addr"},  mem_req_addr, e_addr);
    chk({tag, "_wen"},   mem_req_wen, e_wen);
    chk({tag, "_wdata"}, mem_req_wdata, e_wdata);
    chk({tag, "_wstrb"}, mem_req_wstrb, e_strb);
    tick();
    chk({tag, "_wait"}, {mem_req_valid, lsu_valid, lsu_ready}, 3'b000);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rdata;
    tick();
    mem_resp_valid = 1'b0;
    chk({tag, "_lsuv"}, lsu_valid, 1'b1);
    chk({tag, "_data"}, lsu_data, e_out);
    tick();
    chk({tag, "_idle"}, {lsu_ready, lsu_valid}, 2'b10);
  endtask

  initial begin
    logic [37:0] held;
    rst = 1'b0; exu_valid = 1'b0; exu_data = '0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_rdata = '0; wbu_ready = 1'b1;
    #12;
    chk("rst_ready", lsu_ready, 1'b1);
    chk("rst_outs", {lsu_valid, mem_req_valid, mem_req_wen, mem_req_wstrb}, 7'd0);
    chk("rst_buses", {mem_req_addr, mem_req_wdata}, 64'd0);
    chk("rst_lsu_data", lsu_data, 38'd0);
    tick();
    rst = 1'b1;
    tick();

    // ALU pass-through: OUT one cycle after accept, no memory request.
    exu_valid = 1'b1;
    exu_data  = mk(32'h00001234, 0, 0, 3'b000, 32'h0, 5'd5, 1, 2'b00, 32'hCAFE0000);
    tick();
    exu_valid = 1'b0;
    chk("alu_lsuv", lsu_valid, 1'b1);
    chk("alu_data", lsu_data, {1'b1, 5'd5, 32'h00001234});
    chk("alu_noreq", mem_req_valid, 1'b0);
    tick();
    chk("alu_idle", lsu_ready, 1'b1);

    // CSR select, no memory.
    exu_valid = 1'b1;
    exu_data  = mk(32'h00000010, 0, 0, 3'b000, 32'h0, 5'd9, 1, 2'b10, 32'h0BADF00D);
    tick();
    exu_valid = 1'b0;
    chk("csr_data", lsu_data, {1'b1, 5'd9, 32'h0BADF00D});
    tick();

    run_mem("lb", mk(32'h80000003, 1, 0, 3'b000, 32'h0, 5'd3, 1, 2'b01, 32'h0), 32'h80FFFFFF,
            32'h80000000, 0, 32'h0, 4'b0000, {1'b1, 5'd3, 32'hFFFFFF80});
    run_mem("lhu", mk(32'h80000002, 1, 0, 3'b101, 32'h0, 5'd7, 1, 2'b01, 32'h0), 32'hBEEF1234,
            32'h80000000, 0, 32'h0, 4'b0000, {1'b1, 5'd7, 32'h0000BEEF});
    run_mem("lbu", mk(32'h00000100, 1, 0, 3'b100, 32'h0, 5'd1, 1, 2'b01, 32'h0), 32'h123456F0,
            32'h00000100, 0, 32'h0, 4'b0000, {1'b1, 5'd1, 32'h000000F0});
    run_mem("lh", mk(32'h00000200, 1, 0, 3'b001, 32'h0, 5'd2, 1, 2'b01, 32'h0), 32'h00008001,
            32'h00000200, 0, 32'h0, 4'b0000, {1'b1, 5'd2, 32'hFFFF8001});
    run_mem("lw", mk(32'h00000307, 1, 0, 3'b010, 32'h0, 5'd4, 1, 2'b01, 32'h0), 32'hDEADBEEF,
            32'h00000304, 0, 32'h0, 4'b0000, {1'b1, 5'd4, 32'hDEADBEEF});
    run_mem("sb", mk(32'h80000001, 0, 1, 3'b000, 32'h000000AB, 5'd0, 0, 2'b00, 32'h0), 32'h0,
            32'h80000000, 1, 32'h0000AB00, 4'b0010, {1'b0, 5'd0, 32'h80000001});
    run_mem("sh_mis", mk(32'h80000007, 0, 1, 3'b001, 32'h00001234, 5'd0, 0, 2'b00, 32'h0), 32'h0,
            32'h80000004, 1, 32'h12340000, 4'b1100, {1'b0, 5'd0, 32'h80000007});
    run_mem("sw", mk(32'h00000044, 0, 1, 3'b010, 32'hA5A5C3C3, 5'd0, 0, 2'b00, 32'h0), 32'h0,
            32'h00000044, 1, 32'hA5A5C3C3, 4'b1111, {1'b0, 5'd0, 32'h00000044});
    run_mem("both_ld", mk(32'h00000050, 1, 1, 3'b010, 32'hFFFFFFFF, 5'd6, 1, 2'b01, 32'h0),
            32'h11223344, 32'h00000050, 0, 32'h0, 4'b0000, {1'b1, 5'd6, 32'h11223344});

    // Backpressure on both the request and the writeback side.
    mem_req_ready = 1'b0;
    exu_valid = 1'b1;
    exu_data  = mk(32'h80000001, 0, 1, 3'b000, 32'h000000AB, 5'd0, 0, 2'b00, 32'h0);
    tick();
    exu_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req", {mem_req_valid, mem_req_wen, mem_req_wstrb, lsu_ready}, 7'b1100100);
      chk("bp_bus", {mem_req_addr, mem_req_wdata}, {32'h80000000, 32'h0000AB00});
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("bp_req_last", mem_req_valid, 1'b1);
    tick();
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    wbu_ready = 1'b0;
    held = {1'b0, 5'd0, 32'h80000001};
    for (int i = 0; i < 3; i++) begin
      chk("bp_out", {lsu_valid, lsu_ready}, 2'b10);
      chk("bp_data", lsu_data, held);
      if (i < 2) tick();
    end
    exu_valid = 1'b0;
    wbu_ready = 1'b1;
    tick();
    chk("bp_done", {lsu_ready, lsu_valid}, 2'b10);

    // Reset during WAIT, then a stray response.
    exu_valid = 1'b1;
    exu_data  = mk(32'h80000003, 1, 0, 3'b000, 32'h0, 5'd3, 1, 2'b01, 32'h0);
    tick();
    exu_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_ready", lsu_ready, 1'b1);
    chk("mrst_outs", {lsu_valid, mem_req_valid, mem_req_wen, mem_req_wstrb}, 7'd0);
    chk("mrst_buses", {mem_req_addr, mem_req_wdata}, 64'd0);
    chk("mrst_lsu_data", lsu_data, 38'd0);
    tick();
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h80FFFFFF;
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mrst_quiet", {lsu_valid, mem_req_valid, lsu_ready}, 3'b001);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
